// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } ctrl_state_e;

  localparam logic [4:0]  RegX0      = 5'd0;
  localparam logic [31:0] FlushInstr = 32'b0;

  // x0 is never a real producer, so a load into it cannot create a hazard.
  function automatic logic load_use_hazard(input logic       mem_read,
                                           input logic [4:0] rd,
                                           input logic [4:0] rs1,
                                           input logic [4:0] rs2);
    return mem_read && (rd != RegX0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, data-memory handshake and pipeline-register controls.
interface pipeline_ctrl_if;

  logic [4:0] IFID_rs1;
  logic [4:0] IFID_rs2;
  logic       IDEX_MemRead;
  logic [4:0] IDEX_rd;
  logic       branch_taken;
  logic       mem_access;
  logic       mem_ack;
  logic       mem_req;
  logic       PC_we;
  logic       IFID_en;
  logic       IFID_flush;
  logic       IDEX_en;
  logic       IDEX_bubble;
  logic       EXMEM_en;
  logic       MEMWB_en;

  // Sequencer side.
  modport master (
    input  IFID_rs1, IFID_rs2, IDEX_MemRead, IDEX_rd, branch_taken, mem_access, mem_ack,
    output mem_req, PC_we, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en
  );

  // Datapath / data-memory side.
  modport slave (
    output IFID_rs1, IFID_rs2, IDEX_MemRead, IDEX_rd, branch_taken, mem_access, mem_ack,
    input  mem_req, PC_we, IFID_en, IFID_flush, IDEX_en, IDEX_bubble, EXMEM_en, MEMWB_en
  );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned      Width = 8,
  parameter logic [Width-1:0] Max   = '1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != Max)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with data-memory wait handling.
// Define PIPELINE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned WAIT_W  = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipeline_ctrl_if.master  ctrl,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  ctrl_state_e       state_q, state_d;
  logic              err_q, err_d;
  logic              wait_clear, wait_inc;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_req, freeze, hazard;
  logic pc_we, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en;

  assign hazard = load_use_hazard(ctrl.IDEX_MemRead, ctrl.IDEX_rd, ctrl.IFID_rs1, ctrl.IFID_rs2);

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    freeze      = 1'b0;
    wait_clear  = 1'b0;
    wait_inc    = 1'b0;
    pc_we       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;

    unique case (state_q)
      StRun: begin
        if (ctrl.mem_access && !ctrl.mem_ack) begin
          mem_req    = 1'b1;
          freeze     = 1'b1;
          wait_clear = 1'b1;
          state_d    = StMemWait;
        end
      end
      StMemWait: begin
        mem_req  = 1'b1;
        wait_inc = 1'b1;
        freeze   = !ctrl.mem_ack;
        if (ctrl.mem_ack) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // A memory freeze masks hazards; the held ID/EX inputs replay them afterwards.
    if (freeze) begin
      pc_we    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (hazard) begin
      pc_we       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (ctrl.branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

  assign err_d = err_q | (wait_inc && (wait_cnt == WAIT_W'(TIMEOUT - 1)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  sat_counter #(
    .Width (WAIT_W),
    .Max   (WAIT_W'(TIMEOUT))
  ) u_wait_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (wait_clear),
    .inc_i   (wait_inc),
    .count_o (wait_cnt)
  );

`ifdef PIPELINE_CTRL_PERF_EN
  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .inc_i   (!pc_we),
    .count_o (stall_cnt_o)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .inc_i   (ifid_flush),
    .count_o (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

  assign ctrl.mem_req     = mem_req;
  assign ctrl.PC_we       = pc_we;
  assign ctrl.IFID_en     = ifid_en;
  assign ctrl.IFID_flush  = ifid_flush;
  assign ctrl.IDEX_en     = idex_en;
  assign ctrl.IDEX_bubble = idex_bubble;
  assign ctrl.EXMEM_en    = exmem_en;
  assign ctrl.MEMWB_en    = memwb_en;
  assign err_o            = err_q;

endmodule
